// File: rtl/uart_tx_pkg.sv
// uart_tx_pkg: FSM encoding, register offsets and status bit positions for uart_tx_mmio
package uart_tx_pkg;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;
  localparam logic [1:0] OFF_TXDATA = 2'd0;
  localparam logic [1:0] OFF_STATUS = 2'd1;
  localparam int STAT_BUSY = 0;
  localparam int STAT_FULL = 1;
  localparam int STAT_EMPTY = 2;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO; a push into a full FIFO is taken only alongside a pop
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign do_pop = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign rdata = mem[rd_ptr];
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end
endmodule

// File: rtl/uart_tx_mmio.sv
// uart_tx_mmio: memory-mapped 8N1 transmitter with TX FIFO and status register
module uart_tx_mmio
  import uart_tx_pkg::*;
#(
  parameter int BAUD_DIV = 217,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sel,
  input  logic        mem_valid,
  output logic        mem_ready,
  input  logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        uart_tx
);
  localparam logic [15:0] DIV_M1 = 16'(BAUD_DIV - 1);
  tx_state_t state, state_n;
  logic [15:0] baud_cnt, baud_cnt_n;
  logic [2:0] bit_idx, bit_idx_n;
  logic [7:0] shreg, shreg_n, fifo_rdata;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;
  logic [31:0] status;
  logic [1:0] off;
  logic tx_n, pop, full, empty, req, wr, txw, ack, tick, unused;
  assign unused = ^{mem_addr[31:4], mem_addr[1:0], mem_wdata[31:8], fifo_count};
  assign off = mem_addr[3:2];
  assign req = mem_valid & sel & ~mem_ready;
  assign wr = |mem_wstrb;
  assign txw = req & wr & mem_wstrb[0] & (off == OFF_TXDATA);
  // a full-FIFO write completes on the very edge the FSM frees a slot
  assign ack = req & ~(txw & full & ~pop);
  assign tick = baud_cnt == '0;
  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk), .reset(reset), .push(txw), .pop(pop), .wdata(mem_wdata[7:0]),
    .rdata(fifo_rdata), .full(full), .empty(empty), .count(fifo_count)
  );
  always_comb begin
    status = '0;
    status[STAT_BUSY] = state != IDLE;
    status[STAT_FULL] = full;
    status[STAT_EMPTY] = empty;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_ready <= 1'b0;
      mem_rdata <= '0;
    end else begin
      mem_ready <= ack;
      mem_rdata <= (ack & ~wr & (off == OFF_STATUS)) ? status : '0;
    end
  end
  always_comb begin
    state_n = state;
    baud_cnt_n = (state == IDLE || tick) ? DIV_M1 : baud_cnt - 16'd1;
    bit_idx_n = bit_idx;
    shreg_n = shreg;
    tx_n = uart_tx;
    pop = 1'b0;
    unique case (state)
      IDLE: if (!empty) begin
        pop = 1'b1;
        state_n = START;
        shreg_n = fifo_rdata;
        tx_n = 1'b0;
      end
      START: if (tick) begin
        state_n = DATA;
        tx_n = shreg[0];
        shreg_n = shreg >> 1;
        bit_idx_n = '0;
      end
      DATA: if (tick) begin
        state_n = (bit_idx == 3'd7) ? STOP : DATA;
        tx_n = (bit_idx == 3'd7) ? 1'b1 : shreg[0];
        shreg_n = shreg >> 1;
        bit_idx_n = bit_idx + 3'd1;
      end
      STOP: if (tick) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      baud_cnt <= '0;
      bit_idx <= '0;
      shreg <= '0;
      uart_tx <= 1'b1;
    end else begin
      state <= state_n;
      baud_cnt <= baud_cnt_n;
      bit_idx <= bit_idx_n;
      shreg <= shreg_n;
      uart_tx <= tx_n;
    end
  end
endmodule

// File: tb/tb_uart_tx_mmio.sv
// tb_uart_tx_mmio: directed + random checks of uart_tx_mmio against a line decoder model
module tb_uart_tx_mmio;
  localparam int B = 4;
  logic clk = 1'b0, reset = 1'b1, sel = 1'b1, mem_valid = 1'b0, mem_ready, uart_tx;
  logic [3:0] mem_wstrb = '0;
  logic [31:0] mem_addr = '0, mem_wdata = '0, mem_rdata;
  int total = 0, bad = 0, cyc = 0, last_rst = -1;
  logic lp = 1'b1;
  logic [8:0] rb;
  int t0;
  logic [8:0] rx_q[$];
  int rx_t[$];
  logic [7:0] exp_q[$];
  logic [31:0] rd, a, d;
  logic [3:0] s;
  logic [9:0] fr;
  int lat, n;

  uart_tx_mmio #(.BAUD_DIV(B), .FIFO_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .sel(sel), .mem_valid(mem_valid), .mem_ready(mem_ready),
    .mem_wstrb(mem_wstrb), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .uart_tx(uart_tx)
  );

  always #5 clk = ~clk;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (reset) last_rst <= cyc;
  end

  // receiver model: samples each bit at its centre, stop bit kept in bit 8
  always begin
    @(negedge clk);
    if (lp && !uart_tx && !reset) begin
      t0 = cyc;
      repeat (B / 2) @(negedge clk);
      for (int k = 0; k < 9; k++) begin
        repeat (B) @(negedge clk);
        rb[k] = uart_tx;
      end
      if (last_rst < t0) begin
        rx_q.push_back(rb);
        rx_t.push_back(t0);
      end
    end
    lp = uart_tx;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic bus(input logic [31:0] ad, input logic [3:0] st, input logic [31:0] wd,
                     output logic [31:0] r, output int l);
    if (mem_ready) @(negedge clk);
    mem_valid = 1'b1; mem_addr = ad; mem_wstrb = st; mem_wdata = wd; l = 0;
    do begin
      @(negedge clk);
      l++;
    end while (!mem_ready && l < 200);
    r = mem_rdata;
    mem_valid = 1'b0; mem_wstrb = '0;
  endtask

  task automatic drain(input int cnt, input string tag);
    for (int i = 0; i < 3000 && rx_q.size() < cnt; i++) @(negedge clk);
    chk(tag, 32'(rx_q.size()), 32'(cnt));
    repeat (B + 4) @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_tx", 32'(uart_tx), 32'd1);
    chk("rst_ready", 32'(mem_ready), 32'd0);
    chk("rst_rdata", mem_rdata, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    bus(32'h4, 4'b0000, 32'h0, rd, lat);
    chk("idle_status_lat", 32'(lat), 32'd1);
    chk("idle_status", rd, 32'h4);

    // single 0x55 frame, compared sample by sample
    bus(32'h0, 4'b0001, 32'h55, rd, lat);
    chk("w55_lat", 32'(lat), 32'd1);
    fr = {1'b1, 8'h55, 1'b0};
    for (int i = 0; i < 10 * B; i++) begin
      @(negedge clk);
      chk("w55_line", 32'(uart_tx), 32'(fr[i / B]));
      if (i == 0) chk("rdata_low", mem_rdata, 32'd0);
    end
    drain(1, "w55_frames");
    rx_q.delete(); rx_t.delete();

    // six back-to-back writes: the sixth must wait for the first frame to end
    exp_q.delete();
    for (int i = 0; i < 6; i++) begin
      d = $urandom;
      exp_q.push_back(d[7:0]);
      bus(32'h0, 4'b0001, d, rd, lat);
      if (i < 5) chk("burst_lat", 32'(lat), 32'd1);
      else chk("burst_stall", 32'(lat > 20 && lat < 200), 32'd1);
    end
    bus(32'h4, 4'b0000, 32'h0, rd, lat);
    chk("full_status", rd, 32'h3);
    drain(6, "burst_frames");
    for (int i = 0; i < 6; i++) begin
      chk("burst_byte", 32'(rx_q[i]), 32'({1'b1, exp_q[i]}));
      if (i > 0) chk("burst_period", 32'(rx_t[i] - rx_t[i-1]), 32'(10 * B + 1));
    end

    // write with byte 0 strobe clear: no frame
    rx_q.delete(); rx_t.delete();
    bus(32'h0, 4'b0010, 32'hA5, rd, lat);
    chk("nostrb_lat", 32'(lat), 32'd1);
    repeat (60) @(negedge clk);
    chk("nostrb_frames", 32'(rx_q.size()), 32'd0);
    bus(32'h4, 4'b0000, 32'h0, rd, lat);
    chk("nostrb_status", rd, 32'h4);

    // random writes with interleaved no-effect accesses
    for (int r = 0; r < 3; r++) begin
      rx_q.delete(); rx_t.delete(); exp_q.delete();
      n = 1 + $urandom_range(0, 3);
      for (int i = 0; i < n; i++) begin
        a = $urandom; a[3:2] = 2'b00;
        d = $urandom;
        s = 4'($urandom_range(0, 15)) | 4'b0001;
        exp_q.push_back(d[7:0]);
        bus(a, s, d, rd, lat);
        chk("rnd_lat", 32'(lat), 32'd1);
        repeat ($urandom_range(0, 3)) @(negedge clk);
        if ($urandom_range(0, 1) == 1) begin
          a = $urandom; a[3:2] = 2'($urandom_range(1, 3));
          s = 4'($urandom_range(0, 15));
          if (a[3:2] == 2'b01 && s == 4'b0000) s = 4'b1000;
          bus(a, s, $urandom, rd, lat);
          chk("nop_lat", 32'(lat), 32'd1);
          chk("nop_rdata", rd, 32'd0);
        end
      end
      drain(n, "rnd_frames");
      for (int i = 0; i < n; i++) chk("rnd_byte", 32'(rx_q[i]), 32'({1'b1, exp_q[i]}));
    end

    // reset in the middle of a frame while a write is stalled
    rx_q.delete(); rx_t.delete();
    for (int i = 0; i < 5; i++) bus(32'h0, 4'b0001, 32'(i + 1), rd, lat);
    @(negedge clk);
    mem_valid = 1'b1; mem_addr = 32'h0; mem_wstrb = 4'b0001; mem_wdata = 32'h66;
    repeat (3) begin
      @(negedge clk);
      chk("stall_ready", 32'(mem_ready), 32'd0);
    end
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_tx", 32'(uart_tx), 32'd1);
    chk("midrst_ready", 32'(mem_ready), 32'd0);
    chk("midrst_rdata", mem_rdata, 32'd0);
    reset = 1'b0; mem_valid = 1'b0; mem_wstrb = '0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("post_rst_ready", 32'(mem_ready), 32'd0);
      chk("post_rst_tx", 32'(uart_tx), 32'd1);
    end
    bus(32'h4, 4'b0000, 32'h0, rd, lat);
    chk("post_rst_status", rd, 32'h4);
    repeat (40) @(negedge clk);
    chk("post_rst_frames", 32'(rx_q.size()), 32'd0);

    // request without sel is ignored
    rx_q.delete(); rx_t.delete();
    sel = 1'b0; mem_valid = 1'b1; mem_addr = 32'h0; mem_wstrb = 4'b0001; mem_wdata = 32'h77;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("nosel_ready", 32'(mem_ready), 32'd0);
    end
    mem_valid = 1'b0; mem_wstrb = '0; sel = 1'b1;
    repeat (50) @(negedge clk);
    chk("nosel_frames", 32'(rx_q.size()), 32'd0);
    bus(32'h4, 4'b0000, 32'h0, rd, lat);
    chk("nosel_status", rd, 32'h4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
